// File: rtl/instr_encoder_if.sv
// -----------------------------------------------------------------------------
// instr_encoder_if
// Bundles the two streams around the instruction encoder:
//   request side  : req_valid/req_ready plus the decoded control fields
//   word side     : iw_valid/iw_ready plus iw_addr/iw_data
//   status/control: flush, prog_full, word_count, err
// Modports:
//   master : the program-generation sequencer / consumer side (drives requests,
//            flush and iw_ready; observes everything the encoder produces)
//   slave  : the encoder itself
// -----------------------------------------------------------------------------
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_alu_cmd;
    logic              req_mem_read;
    logic              req_mem_write;
    logic              req_wb_en;
    logic              req_is_imm;
    logic              req_is_branch;
    logic              req_nop;
    logic [1:0]        req_br_type;
    logic [4:0]        req_dst;
    logic [4:0]        req_src1;
    logic [4:0]        req_src2;
    logic [15:0]       req_imm;
    logic              flush;
    logic              iw_valid;
    logic              iw_ready;
    logic [ADDR_W-1:0] iw_addr;
    logic [31:0]       iw_data;
    logic              prog_full;
    logic [ADDR_W:0]   word_count;
    logic              err;

    modport master (
        output req_valid, req_alu_cmd, req_mem_read, req_mem_write, req_wb_en,
               req_is_imm, req_is_branch, req_nop, req_br_type, req_dst,
               req_src1, req_src2, req_imm, flush, iw_ready,
        input  req_ready, iw_valid, iw_addr, iw_data, prog_full, word_count, err
    );

    modport slave (
        input  req_valid, req_alu_cmd, req_mem_read, req_mem_write, req_wb_en,
               req_is_imm, req_is_branch, req_nop, req_br_type, req_dst,
               req_src1, req_src2, req_imm, flush, iw_ready,
        output req_ready, iw_valid, iw_addr, iw_data, prog_full, word_count, err
    );
endinterface

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Turns decoded control requests back into 32-bit instruction words and streams
// them, with consecutive addresses starting at BASE_ADDR, through a 2-entry
// valid/ready buffer toward the instruction-memory loader.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : instr_encoder_if.slave (request stream, word stream, flush,
//          prog_full, word_count, err)
// Parameters:
//   ADDR_W    : word address width, program capacity 2^ADDR_W words
//   BASE_ADDR : address of the first emitted word
// Build option:
//   INSTR_ENCODER_ILLEGAL_TRAP_EN defined   -> illegal requests are accepted,
//       dropped and flagged with a one-cycle err pulse (no address consumed).
//   INSTR_ENCODER_ILLEGAL_TRAP_EN undefined -> illegal requests become NOP
//       words (32'h0) that consume an address; err stays 0.
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic            clk,
    input  logic            rst,
    instr_encoder_if.slave  bus
);

    localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);

    // Returns {illegal, word}. Class priority is nop > branch > load > store >
    // imm > reg; an illegal request always yields an all-zero word.
    function automatic logic [32:0] encode_req(
        input logic [3:0]  alu,
        input logic        rd,
        input logic        wr,
        input logic        wb,
        input logic        imm_f,
        input logic        br,
        input logic        nop,
        input logic [1:0]  brt,
        input logic [4:0]  dst,
        input logic [4:0]  s1,
        input logic [4:0]  s2,
        input logic [15:0] imm
    );
        logic [5:0]  op;
        logic        bad;
        logic [31:0] word;
        op   = 6'd0;
        bad  = rd & wr;
        word = 32'h0000_0000;
        if (nop) begin
            bad  = bad | wb;
            word = 32'h0000_0000;
        end else if (br) begin
            case (brt)
                2'b01:   op = 6'd40;
                2'b10:   op = 6'd41;
                2'b00:   op = 6'd42;
                default: bad = 1'b1;
            endcase
            bad = bad | wb;
            // JMP carries only the offset; the register slots are zero
            if (brt == 2'b00) begin
                word = {op, 10'b0, imm};
            end else begin
                word = {op, s1, s2, imm};
            end
        end else if (rd) begin
            op   = 6'd36;
            bad  = bad | (alu != 4'd0) | ~wb;
            word = {op, dst, s1, imm};
        end else if (wr) begin
            op   = 6'd37;
            bad  = bad | (alu != 4'd0) | wb;
            word = {op, s2, s1, imm};
        end else if (imm_f) begin
            case (alu)
                4'd0:    op = 6'd32;
                4'd2:    op = 6'd33;
                default: bad = 1'b1;
            endcase
            bad  = bad | ~wb;
            word = {op, dst, s1, imm};
        end else begin
            case (alu)
                4'd0:    op = 6'd1;
                4'd2:    op = 6'd3;
                4'd4:    op = 6'd5;
                4'd6:    op = 6'd7;
                4'd7:    op = 6'd8;
                4'd8:    op = 6'd9;
                4'd9:    op = 6'd11;
                4'd10:   op = 6'd12;
                default: bad = 1'b1;
            endcase
            bad  = bad | ~wb;
            word = {op, dst, s1, s2, 11'b0};
        end
        if (bad) begin
            word = 32'h0000_0000;
        end else begin
            word = word;
        end
        return {bad, word};
    endfunction

    logic [ADDR_W-1:0] r_mem_addr [0:1];
    logic [31:0]       r_mem_data [0:1];
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [1:0]        r_occ;
    logic [ADDR_W:0]   r_word_count;
    logic              r_err;

    logic [32:0]       w_enc;
    logic              w_illegal;
    logic [31:0]       w_word;
    logic              w_full;
    logic              w_req_ready;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_err_next;
    logic [ADDR_W-1:0] w_addr;

    // Capacity is exactly 2^ADDR_W, so the counter MSB is the full flag
    assign w_full = r_word_count[ADDR_W];

    // Encode the request and derive handshake / buffer control
    always_comb begin
        w_enc       = encode_req(bus.req_alu_cmd, bus.req_mem_read, bus.req_mem_write,
                                 bus.req_wb_en, bus.req_is_imm, bus.req_is_branch,
                                 bus.req_nop, bus.req_br_type, bus.req_dst,
                                 bus.req_src1, bus.req_src2, bus.req_imm);
        w_illegal   = w_enc[32];
        w_word      = w_enc[31:0];
        w_req_ready = ~rst & ~bus.flush & ~w_full & (r_occ != 2'd2);
        w_accept    = bus.req_valid & w_req_ready;
`ifdef INSTR_ENCODER_ILLEGAL_TRAP_EN
        w_push      = w_accept & ~w_illegal;
        w_err_next  = w_accept & w_illegal;
`else
        // illegal requests already encode to 32'h0, so they push like any word
        w_push      = w_accept;
        w_err_next  = 1'b0;
`endif
        w_pop       = (r_occ != 2'd0) & bus.iw_ready & ~bus.flush;
        w_addr      = LP_BASE + r_word_count[ADDR_W-1:0];
    end

    // Buffer storage, pointers, occupancy, word counter and error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_addr[0] <= '0;
            r_mem_addr[1] <= '0;
            r_mem_data[0] <= 32'h0000_0000;
            r_mem_data[1] <= 32'h0000_0000;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_occ         <= 2'd0;
            r_word_count  <= '0;
            r_err         <= 1'b0;
        end else if (bus.flush) begin
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_occ         <= 2'd0;
            r_word_count  <= '0;
            r_err         <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem_addr[r_wr_ptr] <= w_addr;
                r_mem_data[r_wr_ptr] <= w_word;
                r_wr_ptr             <= ~r_wr_ptr;
                r_word_count         <= r_word_count + {{ADDR_W{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
            r_err <= w_err_next;
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.iw_valid   = (r_occ != 2'd0);
    assign bus.iw_addr    = r_mem_addr[r_rd_ptr];
    assign bus.iw_data    = r_mem_data[r_rd_ptr];
    assign bus.prog_full  = w_full;
    assign bus.word_count = r_word_count;
    assign bus.err        = r_err;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

- Converts decoded control requests back into 32-bit instruction words and streams them, with sequential addresses, toward instruction memory.
- Exact inverse of the pipeline's opcode-to-control decoder: it accepts a request carrying ALU command, memory, writeback, immediate and branch flags plus register/immediate fields, and emits the matching instruction word.
- Sits between the program-generation/test sequencer and the instruction-memory loader.
- Output goes through a 2-entry buffer with a valid/ready handshake.

## Interface
- ADDR_W, 8, instruction-memory address width; program capacity 2^ADDR_W words
- BASE_ADDR, 0, address of the first emitted word
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_alu_cmd  in  4  ALU command
- req_mem_read, req_mem_write, req_wb_en, req_is_imm, req_is_branch, req_nop  in  1 each  control flags
- req_br_type  in  2  01=BEZ, 10=BNE, 00=JMP, 11 illegal
- req_dst, req_src1, req_src2  in  5 each  register fields
- req_imm  in  16  immediate / offset
- flush  in  1  synchronous clear of buffer and address counter
- iw_valid  out  1  word available
- iw_ready  in  1  consumer accepts
- iw_addr  out  ADDR_W  word address
- iw_data  out  32  instruction word
- prog_full  out  1  2^ADDR_W legal words accepted since reset/flush
- word_count  out  ADDR_W+1  legal words accepted
- err  out  1  one-cycle illegal-request pulse

## Operation
- Classification priority: nop > branch > mem_read > mem_write > imm > reg.
- Opcode map:
  - NOP: 0
  - reg ops, by alu_cmd: 0000→1, 0010→3, 0100→5, 0110→7, 0111→8, 1000→9, 1001→11, 1010→12
  - imm ops: 0000→32, 0010→33
  - load→36, store→37
  - BEZ→40, BNE→41, JMP→42
- Word formats:
  - reg: {op, dst, src1, src2, 11'b0}
  - imm/load: {op, dst, src1, imm}
  - store: {op, src2, src1, imm}
  - BEZ/BNE: {op, src1, src2, imm}
  - JMP: {op, 10'b0, imm}
  - NOP: 32'h0
- Illegal requests:
  - mem_read & mem_write both set
  - br_type 11
  - alu_cmd not in the map for its class
  - load/store with alu_cmd≠0000
  - wb_en≠1 for reg/imm/load, or wb_en≠0 for store/branch/NOP
- Addressing:
  - Each accepted legal (or NOP-substituted) word takes address (BASE_ADDR + word_count) mod 2^ADDR_W; word_count then increments.
  - No wrap: at word_count = 2^ADDR_W, prog_full=1 and req_ready=0 until flush or reset.
- req_ready = !rst & !flush & !prog_full & (buffer occupancy < 2).
- Buffer: 2-entry FIFO of {addr, data}; head drives iw_addr/iw_data, popped on iw_valid & iw_ready.
- flush: same cycle, empties the buffer, zeroes word_count and prog_full, drops any concurrent request (req_ready=0) and any concurrent pop.

## Timing
- Reset values: iw_valid=0, iw_addr=0, iw_data=0, prog_full=0, word_count=0, err=0; req_ready=0 while rst=1.
- Latency: request accepted at edge N with buffer empty → iw_valid=1 after edge N, with that word's addr/data.
- Throughput: 1 word/cycle while occupancy ≤1 and iw_ready=1.
- Simultaneous push and pop at occupancy 1: occupancy stays 1 and the order is preserved.
- At occupancy 2, req_ready=0; no pass-through.
- iw_addr and iw_data are held stable while iw_valid & !iw_ready.
- word_count and prog_full update on the accepting edge.
- err is registered: high for exactly the cycle after an illegal accept.
- Asserting rst mid-stream drops buffered words immediately and restarts at BASE_ADDR.

## Configuration
- Macro: INSTR_ENCODER_ILLEGAL_TRAP_EN.
- Defined: an illegal request is accepted and dropped. It pulses err, consumes no address, and writes nothing to the buffer.
- Undefined: an illegal request is encoded as NOP (32'h0) and consumes an address like a legal word; err is tied to 0.

## Test plan
- Reset, then reg ADD (alu 0000, wb_en=1, dst=3, src1=1, src2=2) → one cycle later iw_valid=1, iw_addr=0, iw_data=32'h04611000.
- Stream addi (alu 0000, imm, dst=4, src1=0, imm=16'h0005), load (36), store (37), BNE (41) with iw_ready=1 → words at addresses 0..3, opcodes 32/36/37/41, one per cycle.
- iw_ready=0 while issuing 3 requests → two buffered, req_ready=0 on the third, iw_data held; raise iw_ready → in-order drain, third accepted.
- ADDR_W=2: accept 4 words → prog_full=1, req_ready=0, word_count=4; flush → word_count=0, next word at BASE_ADDR.
- Request with mem_read=mem_write=1:
  - With INSTR_ENCODER_ILLEGAL_TRAP_EN: err pulses one cycle and word_count is unchanged.
  - Without: word 32'h0 is emitted and word_count increments.
- Assert rst mid-drain with 2 words buffered → iw_valid=0 immediately, all outputs at reset values.
